// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: FSM states,
// opcodes, ALU operation codes, instruction classes and the bit positions
// of the datapath's load strobes and bus-source selects.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        F0, F1, F2, DEC, T3, T4, T5, T6, T7, HALT
    } ctrlState_t;

    typedef enum logic [3:0] {
        clsLd, clsSt, clsAlu, clsAddi, clsUnary, clsMulDiv, clsBr,
        clsJr, clsIn, clsOut, clsMfhi, clsMflo, clsNop, clsHalt
    } instrClass_t;

    localparam logic [4:0] opLd   = 5'd0;
    localparam logic [4:0] opSt   = 5'd1;
    localparam logic [4:0] opAdd  = 5'd2;
    localparam logic [4:0] opRol  = 5'd9;
    localparam logic [4:0] opAddi = 5'd10;
    localparam logic [4:0] opNeg  = 5'd11;
    localparam logic [4:0] opNot  = 5'd12;
    localparam logic [4:0] opMul  = 5'd13;
    localparam logic [4:0] opDiv  = 5'd14;
    localparam logic [4:0] opBr   = 5'd15;
    localparam logic [4:0] opJr   = 5'd16;
    localparam logic [4:0] opIn   = 5'd17;
    localparam logic [4:0] opOut  = 5'd18;
    localparam logic [4:0] opMfhi = 5'd19;
    localparam logic [4:0] opMflo = 5'd20;
    localparam logic [4:0] opNop  = 5'd21;
    localparam logic [4:0] opHalt = 5'd22;

    localparam logic [3:0] aluAdd = 4'd0;
    localparam logic [3:0] aluNeg = 4'd8;
    localparam logic [3:0] aluNot = 4'd9;
    localparam logic [3:0] aluMul = 4'd10;
    localparam logic [3:0] aluDiv = 4'd11;
    localparam logic [3:0] aluInc = 4'd12;

    localparam int enHi      = 16;
    localparam int enLo      = 17;
    localparam int enPc      = 20;
    localparam int enMdr     = 21;
    localparam int enIr      = 23;
    localparam int enZ       = 24;
    localparam int enMar     = 25;
    localparam int enOutport = 26;
    localparam int enY       = 27;

    localparam int busHi     = 16;
    localparam int busLo     = 17;
    localparam int busZhi    = 18;
    localparam int busZlo    = 19;
    localparam int busPc     = 20;
    localparam int busMdr    = 21;
    localparam int busInport = 22;
    localparam int busC      = 23;

    // Final execute state of each class; the FSM returns to F0 after it.
    function automatic ctrlState_t lastState(input instrClass_t cls);
        case (cls)
            clsLd, clsSt:                return T7;
            clsAlu, clsAddi, clsBr:      return T5;
            clsUnary:                    return T4;
            clsMulDiv:                   return T6;
            default:                     return T3;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational IR decode: instruction class, ALU code for the class and
// one-hot register selects for the ra/rb/rc fields. Unknown opcodes become NOP.
// CTRL_SEQ_MULDIV_EN: when defined MUL/DIV get their own class, otherwise
// they decode as NOP so the multiply/divide ALU codes are never issued.
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output instrClass_t opClass,
    output logic [3:0]  aluOp,
    output logic [15:0] raSel,
    output logic [15:0] rbSel,
    output logic [15:0] rcSel
);

    logic [4:0] opcode;

    assign opcode = ir[31:27];
    assign raSel  = 16'b1 << ir[26:23];
    assign rbSel  = 16'b1 << ir[22:19];
    assign rcSel  = 16'b1 << ir[18:15];

    // Map opcode to execution class and the ALU code that class uses.
    always_comb begin
        opClass = clsNop;
        aluOp   = aluAdd;
        if (opcode >= opAdd && opcode <= opRol) begin
            opClass = clsAlu;
            aluOp   = opcode[3:0] - 4'd2;
        end else begin
            case (opcode)
                opLd:   opClass = clsLd;
                opSt:   opClass = clsSt;
                opAddi: opClass = clsAddi;
                opNeg:  begin opClass = clsUnary; aluOp = aluNeg; end
                opNot:  begin opClass = clsUnary; aluOp = aluNot; end
                opMul, opDiv: begin
`ifdef CTRL_SEQ_MULDIV_EN
                    opClass = clsMulDiv;
                    aluOp   = (opcode == opMul) ? aluMul : aluDiv;
`else
                    opClass = clsNop;
`endif
                end
                opBr:   opClass = clsBr;
                opJr:   opClass = clsJr;
                opIn:   opClass = clsIn;
                opOut:  opClass = clsOut;
                opMfhi: opClass = clsMfhi;
                opMflo: opClass = clsMflo;
                opHalt: opClass = clsHalt;
                default: opClass = clsNop;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the CPU datapath: fetch, decode and
// per-class execute steps driving load strobes, bus source, ALU op and the
// memory handshake. Waits on mem_ready in F1 (fetch), LD T6 and ST T7.
// CTRL_SEQ_MULDIV_EN enables the MUL/DIV execute sequence (see instr_decode).
//
// state | meaning
// F0    | PC to MAR, Z = PC+1
// F1    | PC = Z, MDR <- memory; held until mem_ready
// F2    | IR <- MDR
// DEC   | decode; HALT or first execute step
// T3-T7 | class-specific execute steps
// HALT  | stopped until reset
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    output logic [31:0] enable,
    output logic [31:0] bus_select,
    output logic [3:0]  alu_op,
    output logic        md_read,
    output logic        mem_write,
    output logic        run
);

    ctrlState_t  state, nextState;
    instrClass_t opClass;
    logic [3:0]  aluOp;
    logic [15:0] raSel, rbSel, rcSel;

    instr_decode uDecode (
        .ir      (ir),
        .opClass (opClass),
        .aluOp   (aluOp),
        .raSel   (raSel),
        .rbSel   (rbSel),
        .rcSel   (rcSel)
    );

    // State register; reset returns to the start of fetch.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= F0;
        else      state <= nextState;
    end

    // Next-state and Moore output decode; outputs are forced quiet during reset.
    always_comb begin
        nextState  = state;
        enable     = '0;
        bus_select = '0;
        alu_op     = aluAdd;
        md_read    = 1'b0;
        mem_write  = 1'b0;
        run        = 1'b1;
        unique case (state)
            F0: begin
                bus_select[busPc] = 1'b1;
                enable[enMar]     = 1'b1;
                enable[enZ]       = 1'b1;
                alu_op            = aluInc;
                nextState         = F1;
            end
            F1: begin
                bus_select[busZlo] = 1'b1;
                enable[enPc]       = 1'b1;
                enable[enMdr]      = 1'b1;
                md_read            = 1'b1;
                if (mem_ready) nextState = F2;
            end
            F2: begin
                bus_select[busMdr] = 1'b1;
                enable[enIr]       = 1'b1;
                nextState          = DEC;
            end
            DEC: nextState = (opClass == clsHalt) ? HALT : T3;
            T3: begin
                case (opClass)
                    clsLd, clsSt, clsAlu, clsAddi: begin
                        bus_select[15:0] = rbSel;
                        enable[enY]      = 1'b1;
                    end
                    clsUnary: begin
                        bus_select[15:0] = rbSel;
                        enable[enZ]      = 1'b1;
                        alu_op           = aluOp;
                    end
                    clsMulDiv: begin
                        bus_select[15:0] = raSel;
                        enable[enY]      = 1'b1;
                    end
                    clsBr: begin
                        bus_select[busPc] = 1'b1;
                        enable[enY]       = 1'b1;
                    end
                    clsJr: begin
                        bus_select[15:0] = raSel;
                        enable[enPc]     = 1'b1;
                    end
                    clsIn: begin
                        bus_select[busInport] = 1'b1;
                        enable[15:0]          = raSel;
                    end
                    clsOut: begin
                        bus_select[15:0]  = raSel;
                        enable[enOutport] = 1'b1;
                    end
                    clsMfhi: begin
                        bus_select[busHi] = 1'b1;
                        enable[15:0]      = raSel;
                    end
                    clsMflo: begin
                        bus_select[busLo] = 1'b1;
                        enable[15:0]      = raSel;
                    end
                    default: ;
                endcase
                nextState = (lastState(opClass) == T3) ? F0 : T4;
            end
            T4: begin
                case (opClass)
                    clsAlu: begin
                        bus_select[15:0] = rcSel;
                        enable[enZ]      = 1'b1;
                        alu_op           = aluOp;
                    end
                    clsMulDiv: begin
                        bus_select[15:0] = rbSel;
                        enable[enZ]      = 1'b1;
                        alu_op           = aluOp;
                    end
                    clsAddi, clsLd, clsSt, clsBr: begin
                        bus_select[busC] = 1'b1;
                        enable[enZ]      = 1'b1;
                    end
                    clsUnary: begin
                        bus_select[busZlo] = 1'b1;
                        enable[15:0]       = raSel;
                    end
                    default: ;
                endcase
                nextState = (lastState(opClass) == T4) ? F0 : T5;
            end
            T5: begin
                bus_select[busZlo] = 1'b1;
                case (opClass)
                    clsAlu, clsAddi: enable[15:0] = raSel;
                    clsLd, clsSt:    enable[enMar] = 1'b1;
                    clsBr:           enable[enPc] = con_ff;
                    clsMulDiv:       enable[enLo] = 1'b1;
                    default:         bus_select[busZlo] = 1'b0;
                endcase
                nextState = (lastState(opClass) == T5) ? F0 : T6;
            end
            T6: begin
                case (opClass)
                    clsLd: begin
                        md_read       = 1'b1;
                        enable[enMdr] = 1'b1;
                    end
                    clsSt: begin
                        bus_select[15:0] = raSel;
                        enable[enMdr]    = 1'b1;
                    end
                    clsMulDiv: begin
                        bus_select[busZhi] = 1'b1;
                        enable[enHi]       = 1'b1;
                    end
                    default: ;
                endcase
                if (opClass == clsLd && !mem_ready) nextState = T6;
                else if (lastState(opClass) == T6)  nextState = F0;
                else                                nextState = T7;
            end
            T7: begin
                case (opClass)
                    clsLd: begin
                        bus_select[busMdr] = 1'b1;
                        enable[15:0]       = raSel;
                    end
                    clsSt:   mem_write = 1'b1;
                    default: ;
                endcase
                nextState = (opClass == clsSt && !mem_ready) ? T7 : F0;
            end
            HALT: run = 1'b0;
            default: nextState = F0;
        endcase
        if (!clr) begin
            enable     = '0;
            bus_select = '0;
            alu_op     = aluAdd;
            md_read    = 1'b0;
            mem_write  = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instructions plus randomized
// instruction/condition/memory-wait stimulus, checked cycle by cycle against
// a per-class micro-step list built from the instruction set description.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        con_ff;
    logic        mem_ready;
    logic [31:0] enable;
    logic [31:0] bus_select;
    logic [3:0]  alu_op;
    logic        md_read;
    logic        mem_write;
    logic        run;

    control_sequencer dut (
        .clk        (clk),
        .clr        (clr),
        .ir         (ir),
        .con_ff     (con_ff),
        .mem_ready  (mem_ready),
        .enable     (enable),
        .bus_select (bus_select),
        .alu_op     (alu_op),
        .md_read    (md_read),
        .mem_write  (mem_write),
        .run        (run)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] en;
        logic [31:0] bus;
        logic [3:0]  alu;
        logic        mdr;
        logic        mw;
        int          waitKind;   // 0 none, 1 fetch wait, 2 execute wait
    } step_t;

    step_t stepQ[$];
    bit    haltsAfter;
    int    passCnt  = 0;
    int    checkCnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs === exp) passCnt++;
        else $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] bit1(input int n);
        logic [31:0] one;
        one = 32'd1;
        return (n < 0) ? 32'd0 : (one << n);
    endfunction

    task automatic push(input int busBit, input logic [31:0] en, input int alu,
                        input bit mdr, input bit mw, input int waitKind);
        step_t s;
        s.bus = bit1(busBit);
        s.en = en;
        s.alu = 4'(alu);
        s.mdr = mdr;
        s.mw = mw;
        s.waitKind = waitKind;
        stepQ.push_back(s);
    endtask

    // Expected register transfers for one instruction, one entry per step.
    task automatic buildSteps(input logic [31:0] irv, input bit cf);
        int op, ra, rb, rc;
        op = int'(irv[31:27]);
        ra = int'(irv[26:23]);
        rb = int'(irv[22:19]);
        rc = int'(irv[18:15]);
        stepQ.delete();
        haltsAfter = 0;
        push(20, bit1(25) | bit1(24), 12, 0, 0, 0);
        push(19, bit1(20) | bit1(21), 0, 1, 0, 1);
        push(21, bit1(23), 0, 0, 0, 0);
        push(-1, 0, 0, 0, 0, 0);
        if (op >= 2 && op <= 10) begin
            push(rb, bit1(27), 0, 0, 0, 0);
            push((op == 10) ? 23 : rc, bit1(24), (op == 10) ? 0 : op - 2, 0, 0, 0);
            push(19, bit1(ra), 0, 0, 0, 0);
        end else begin
            case (op)
                0, 1: begin
                    push(rb, bit1(27), 0, 0, 0, 0);
                    push(23, bit1(24), 0, 0, 0, 0);
                    push(19, bit1(25), 0, 0, 0, 0);
                    if (op == 0) begin
                        push(-1, bit1(21), 0, 1, 0, 2);
                        push(21, bit1(ra), 0, 0, 0, 0);
                    end else begin
                        push(ra, bit1(21), 0, 0, 0, 0);
                        push(-1, 0, 0, 0, 1, 2);
                    end
                end
                11, 12: begin
                    push(rb, bit1(24), op - 3, 0, 0, 0);
                    push(19, bit1(ra), 0, 0, 0, 0);
                end
                13, 14: begin
`ifdef CTRL_SEQ_MULDIV_EN
                    push(ra, bit1(27), 0, 0, 0, 0);
                    push(rb, bit1(24), op - 3, 0, 0, 0);
                    push(19, bit1(17), 0, 0, 0, 0);
                    push(18, bit1(16), 0, 0, 0, 0);
`else
                    push(-1, 0, 0, 0, 0, 0);
`endif
                end
                15: begin
                    push(20, bit1(27), 0, 0, 0, 0);
                    push(23, bit1(24), 0, 0, 0, 0);
                    push(19, cf ? bit1(20) : 32'd0, 0, 0, 0, 0);
                end
                16: push(ra, bit1(20), 0, 0, 0, 0);
                17: push(22, bit1(ra), 0, 0, 0, 0);
                18: push(ra, bit1(26), 0, 0, 0, 0);
                19: push(16, bit1(ra), 0, 0, 0, 0);
                20: push(17, bit1(ra), 0, 0, 0, 0);
                22: haltsAfter = 1;
                default: push(-1, 0, 0, 0, 0, 0);
            endcase
        end
    endtask

    // Runs one instruction starting just after the edge that entered F0.
    // execWaits < 0: random mem_ready everywhere; otherwise that many low
    // cycles at the first execute wait step and mem_ready high elsewhere.
    task automatic runInstr(input logic [31:0] irv, input bit cf, input int execWaits,
                            output int cycles);
        int idx, waitLeft, lowRun;
        step_t s;
        buildSteps(irv, cf);
        ir = irv;
        con_ff = cf;
        cycles = 0;
        idx = 0;
        lowRun = 0;
        waitLeft = execWaits;
        while (idx < stepQ.size()) begin
            @(negedge clk);
            cycles++;
            s = stepQ[idx];
            check($sformatf("enable op%0d step%0d", irv[31:27], idx), enable, s.en);
            check($sformatf("bus_select op%0d step%0d", irv[31:27], idx), bus_select, s.bus);
            check($sformatf("alu_op op%0d step%0d", irv[31:27], idx), 32'(alu_op), 32'(s.alu));
            check($sformatf("md_read op%0d step%0d", irv[31:27], idx), 32'(md_read), 32'(s.mdr));
            check($sformatf("mem_write op%0d step%0d", irv[31:27], idx), 32'(mem_write), 32'(s.mw));
            check($sformatf("run op%0d step%0d", irv[31:27], idx), 32'(run), 32'd1);
            check("bus_select onehot0", 32'($onehot0(bus_select)), 32'd1);
            if (execWaits < 0)
                mem_ready = (s.waitKind != 0 && lowRun >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
            else if (s.waitKind == 2 && waitLeft > 0) begin
                mem_ready = 1'b0;
                waitLeft--;
            end else
                mem_ready = 1'b1;
            if (s.waitKind != 0 && !mem_ready) lowRun++;
            else begin
                lowRun = 0;
                idx++;
            end
        end
        @(posedge clk);
        #1;
        if (!haltsAfter) begin
            check("back to F0 bus_select", bus_select, bit1(20));
        end else begin
            repeat (20) begin
                @(negedge clk);
                mem_ready = 1'($urandom_range(0, 1));
                check("halt run", 32'(run), 32'd0);
                check("halt enable", enable, 32'd0);
                check("halt bus_select", bus_select, 32'd0);
                check("halt ctl", {alu_op, md_read, mem_write}, 32'd0);
            end
            clr = 1'b0;
            #1;
            check("halt reset run", 32'(run), 32'd1);
            check("halt reset enable", enable, 32'd0);
            @(posedge clk);
            #1;
            clr = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [31:0] irv;
        int op;
        clr = 1'b0;
        ir = 32'd0;
        con_ff = 1'b0;
        mem_ready = 1'b1;
        #3;
        check("reset enable", enable, 32'd0);
        check("reset bus_select", bus_select, 32'd0);
        check("reset alu_op", 32'(alu_op), 32'd0);
        check("reset md_read", 32'(md_read), 32'd0);
        check("reset mem_write", 32'(mem_write), 32'd0);
        check("reset run", 32'(run), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;

        runInstr(32'h1190_8000, 0, 0, cyc);
        check("cycles ADD", cyc, 7);
        runInstr({5'd0, 4'd5, 4'd2, 19'h00123}, 0, 3, cyc);
        check("cycles LD 3 waits", cyc, 12);
        runInstr({5'd1, 4'd7, 4'd4, 19'h7ffff}, 0, 0, cyc);
        check("cycles ST", cyc, 9);
        runInstr({5'd15, 4'd0, 4'd0, 19'h00010}, 0, 0, cyc);
        check("cycles BR not taken", cyc, 7);
        runInstr({5'd15, 4'd0, 4'd0, 19'h00010}, 1, 0, cyc);
        check("cycles BR taken", cyc, 7);
        runInstr({5'd11, 4'd9, 4'd6, 19'h0}, 0, 0, cyc);
        check("cycles NEG", cyc, 6);
        runInstr({5'd16, 4'd12, 4'd0, 19'h0}, 0, 0, cyc);
        check("cycles JR", cyc, 5);
        runInstr({5'd21, 27'h0}, 0, 0, cyc);
        check("cycles NOP", cyc, 5);
        runInstr({5'd13, 4'd1, 4'd2, 19'h0}, 0, 0, cyc);
`ifdef CTRL_SEQ_MULDIV_EN
        check("cycles MUL", cyc, 8);
`else
        check("cycles MUL as NOP", cyc, 5);
`endif
        runInstr({5'd22, 27'h0}, 0, 0, cyc);

        // Abort an LD partway through with reset.
        ir = {5'd0, 4'd3, 4'd1, 19'h4};
        repeat (6) @(negedge clk);
        clr = 1'b0;
        #1;
        check("abort enable", enable, 32'd0);
        check("abort bus_select", bus_select, 32'd0);
        check("abort run", 32'(run), 32'd1);
        @(posedge clk);
        #1;
        clr = 1'b1;

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 31);
            irv = {5'(op), 27'($urandom)};
            runInstr(irv, 1'($urandom_range(0, 1)), -1, cyc);
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
